// File: rtl/mc_bus_bridge.sv
// Bridges the MCU asynchronous SRAM-style bus into the system clock domain.
// Each synchronised MCU cycle becomes exactly one clocked register-bank write or read.
module mc_bus_bridge #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADD_WIDTH   = 6,
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mc_ce,
  input  logic                  mc_oe,
  input  logic                  mc_we,
  input  logic [ADD_WIDTH-1:0]  mc_add,
  input  logic [DATA_WIDTH-1:0] mc_data_in,
  output logic [DATA_WIDTH-1:0] mc_data_out,
  output logic                  mc_data_oe,
  output logic [ADD_WIDTH-1:0]  reg_add,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_rvalid,
  output logic                  protocol_err,
  output logic [2:0]            fsm_state
);

  localparam int CNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      TMO_CNT   = CNT_W'(RD_TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] DEAD_WORD = DATA_WIDTH'(16'hDEAD);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_WAIT  = 3'd2,
    RD_DRIVE = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  // Synchronisers: strobes idle high, bus lines idle low.
  logic [SYNC_STAGES-1:0] ce_sync, oe_sync, we_sync;
  logic [ADD_WIDTH-1:0]   add_sync  [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]  data_sync [SYNC_STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      ce_sync <= '1;
      oe_sync <= '1;
      we_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        add_sync[i]  <= '0;
        data_sync[i] <= '0;
      end
    end else begin
      ce_sync      <= {ce_sync[SYNC_STAGES-2:0], mc_ce};
      oe_sync      <= {oe_sync[SYNC_STAGES-2:0], mc_oe};
      we_sync      <= {we_sync[SYNC_STAGES-2:0], mc_we};
      add_sync[0]  <= mc_add;
      data_sync[0] <= mc_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        add_sync[i]  <= add_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  logic                  s_ce, s_oe, s_we;
  logic [ADD_WIDTH-1:0]  s_add;
  logic [DATA_WIDTH-1:0] s_data;

  assign s_ce   = ce_sync[SYNC_STAGES-1];
  assign s_oe   = oe_sync[SYNC_STAGES-1];
  assign s_we   = we_sync[SYNC_STAGES-1];
  assign s_add  = add_sync[SYNC_STAGES-1];
  assign s_data = data_sync[SYNC_STAGES-1];

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      rd_cnt, rd_cnt_nxt;
  logic [ADD_WIDTH-1:0]  reg_add_nxt;
  logic [DATA_WIDTH-1:0] reg_wdata_nxt, data_out_nxt;
  logic                  reg_wr_nxt, reg_rd_nxt;
  logic                  data_oe_q, data_oe_nxt;
  logic                  perr_nxt;

  // Read handshake: reg_rd is a single-cycle request; the bank answers with
  // reg_rvalid/reg_rdata in any later cycle, and a response arriving in the
  // reg_rd cycle itself or after the request was abandoned is dropped.
  always_comb begin
    state_nxt     = state;
    rd_cnt_nxt    = rd_cnt;
    reg_add_nxt   = reg_add;
    reg_wdata_nxt = reg_wdata;
    data_out_nxt  = mc_data_out;
    data_oe_nxt   = data_oe_q;
    perr_nxt      = protocol_err;
    reg_wr_nxt    = 1'b0;
    reg_rd_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (!s_ce) begin
          if (!s_we && !s_oe) begin
            perr_nxt  = 1'b1;
            state_nxt = RELEASE;
          end else if (!s_we) begin
            reg_add_nxt   = s_add;
            reg_wdata_nxt = s_data;
            state_nxt     = WRITE;
          end else if (!s_oe) begin
            reg_add_nxt = s_add;
            reg_rd_nxt  = 1'b1;
            rd_cnt_nxt  = '0;
            state_nxt   = RD_WAIT;
          end
        end
      end

      // Commit on the trailing strobe edge with the last values seen while asserted.
      WRITE: begin
        if (!s_ce && !s_we) begin
          reg_add_nxt   = s_add;
          reg_wdata_nxt = s_data;
        end else begin
          reg_wr_nxt = 1'b1;
          state_nxt  = s_ce ? IDLE : RELEASE;
        end
      end

      RD_WAIT: begin
        if (s_ce || s_oe) begin
          state_nxt = IDLE;
        end else if ((rd_cnt != '0) && reg_rvalid) begin
          data_out_nxt = reg_rdata;
          data_oe_nxt  = 1'b1;
          state_nxt    = RD_DRIVE;
        end else if (rd_cnt == TMO_CNT) begin
          data_out_nxt = DEAD_WORD;
          data_oe_nxt  = 1'b1;
          perr_nxt     = 1'b1;
          state_nxt    = RD_DRIVE;
        end else begin
          rd_cnt_nxt = rd_cnt + CNT_W'(1);
        end
      end

      RD_DRIVE: begin
        if (s_ce || s_oe) begin
          data_oe_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end

      RELEASE: begin
        if (s_ce) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      rd_cnt       <= '0;
      reg_add      <= '0;
      reg_wdata    <= '0;
      reg_wr       <= 1'b0;
      reg_rd       <= 1'b0;
      mc_data_out  <= '0;
      data_oe_q    <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      rd_cnt       <= rd_cnt_nxt;
      reg_add      <= reg_add_nxt;
      reg_wdata    <= reg_wdata_nxt;
      reg_wr       <= reg_wr_nxt;
      reg_rd       <= reg_rd_nxt;
      mc_data_out  <= data_out_nxt;
      data_oe_q    <= data_oe_nxt;
      protocol_err <= perr_nxt;
    end
  end

  // Gating with s_we keeps the bridge off the bus whenever the MCU is writing.
  assign mc_data_oe = data_oe_q & s_we;
  assign fsm_state  = state;

endmodule
